// File: rtl/mem_stage.sv
// Memory-access pipeline stage: one load/store at a time on a req/gnt/rvalid bus.
// It aligns load data, formats store lanes, flags misalignment and registers the WB state.
package riscv_pkg;
  localparam int TAG_WIDTH = 4;
  typedef enum logic {LSU_LOAD = 1'b0, LSU_STORE = 1'b1} lsu_op_e;
  typedef enum logic [2:0] {
    LSU_B  = 3'b000, LSU_H  = 3'b001, LSU_W = 3'b010,
    LSU_BU = 3'b100, LSU_HU = 3'b101
  } lsu_dtype_e;
endpackage

module mem_stage
  import riscv_pkg::*;
#(
  parameter bit MISALIGN_EXC_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 stall_M,
  input  logic                 flush_M,
  input  logic                 ready_wb,
  output logic                 ready_mem,
  input  logic                 lsu_en_mem,
  input  lsu_op_e              lsu_op_mem,
  input  lsu_dtype_e           lsu_dtype_mem,
  input  logic [31:0]          lsu_addr_mem,
  input  logic [31:0]          lsu_wdata_mem,
  input  logic                 rd_wr_en_mem,
  input  logic [TAG_WIDTH-1:0] rd_wr_tag_mem,
  input  logic [4:0]           rd_wr_addr_mem,
  input  logic [31:0]          rd_wr_data_mem,
  input  logic [31:0]          pc_mem,
  input  logic                 exc_taken_mem,
  output logic                 data_req,
  output logic                 data_we,
  output logic [31:0]          data_addr,
  output logic [3:0]           data_be,
  output logic [31:0]          data_wdata,
  input  logic                 data_gnt,
  input  logic                 data_rvalid,
  input  logic                 data_err,
  input  logic [31:0]          data_rdata,
  output logic                 rd_wr_en_wb,
  output logic [TAG_WIDTH-1:0] rd_wr_tag_wb,
  output logic [4:0]           rd_wr_addr_wb,
  output logic [31:0]          rd_wr_data_wb,
  output logic [31:0]          pc_wb,
  output logic                 exc_taken_wb,
  output logic                 lsu_misalign_ld,
  output logic                 lsu_misalign_st,
  output logic                 lsu_bus_err,
  output logic [31:0]          lsu_exc_addr,
  output logic                 forward_mem_en,
  output logic [TAG_WIDTH-1:0] forward_mem_tag,
  output logic [4:0]           forward_mem_addr,
  output logic [31:0]          forward_mem_wdata
);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID} state_e;

  function automatic logic [3:0] store_be(input lsu_dtype_e dt, input logic [1:0] off);
    case (dt)
      LSU_B, LSU_BU: store_be = 4'b0001 << off;
      LSU_H, LSU_HU: store_be = 4'b0011 << off;
      default:       store_be = 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input lsu_dtype_e dt, input logic [31:0] wd);
    case (dt)
      LSU_B, LSU_BU: store_data = {4{wd[7:0]}};
      LSU_H, LSU_HU: store_data = {2{wd[15:0]}};
      default:       store_data = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_data(input lsu_dtype_e dt, input logic [1:0] off,
                                            input logic [31:0] rdata);
    logic [31:0] sh;
    sh = rdata >> {off, 3'b000};
    case (dt)
      LSU_B:   load_data = {{24{sh[7]}}, sh[7:0]};
      LSU_BU:  load_data = {24'h0, sh[7:0]};
      LSU_H:   load_data = {{16{sh[15]}}, sh[15:0]};
      LSU_HU:  load_data = {16'h0, sh[15:0]};
      default: load_data = sh;
    endcase
  endfunction

  state_e      state;
  logic        flush_pending;
  logic        ld_done;
  logic        ld_done_err;
  logic [31:0] ld_done_data;

  logic        is_load, is_half, is_word, access, mis, bus_op;
  logic [1:0]  off;
  logic        req_idle, rsp, busy, advance, kill;
  logic        res_valid, res_err, mis_exc, bus_exc;
  logic [31:0] res_data;

  assign is_load = (lsu_op_mem == LSU_LOAD);
  assign is_half = (lsu_dtype_mem == LSU_H) || (lsu_dtype_mem == LSU_HU);
  assign is_word = (lsu_dtype_mem == LSU_W);
  assign access  = lsu_en_mem & ~exc_taken_mem;
  assign mis     = MISALIGN_EXC_EN &
                   ((is_half & lsu_addr_mem[0]) | (is_word & (lsu_addr_mem[1:0] != 2'b00)));
  // Masking is a no-op for aligned accesses, so it also covers the non-trapping mode.
  assign off     = is_word ? 2'b00 : (is_half ? {lsu_addr_mem[1], 1'b0} : lsu_addr_mem[1:0]);
  assign bus_op  = access & ~mis;

  assign req_idle  = (state == IDLE) & bus_op & ~ld_done & ~flush_M & ~stall_M;
  assign data_req  = req_idle | (state == WAIT_GNT);
  assign data_we   = data_req & ~is_load;
  assign data_addr = data_req ? {lsu_addr_mem[31:2], 2'b00} : 32'h0;
  assign data_be   = data_req ? store_be(lsu_dtype_mem, off) : 4'h0;
  assign data_wdata = data_req ? store_data(lsu_dtype_mem, lsu_wdata_mem) : 32'h0;

  assign rsp       = (state == WAIT_RVALID) & data_rvalid;
  assign res_valid = rsp | ld_done;
  assign res_err   = ld_done ? ld_done_err : data_err;
  assign res_data  = ld_done ? ld_done_data : load_data(lsu_dtype_mem, off, data_rdata);

  assign busy      = ((state == IDLE) & bus_op & ~ld_done) | (state == WAIT_GNT) |
                     ((state == WAIT_RVALID) & ~data_rvalid);
  assign ready_mem = ~stall_M & ready_wb & ~busy;
  assign advance   = ~stall_M & ready_wb;
  assign kill      = flush_M | flush_pending;
  assign mis_exc   = access & mis;
  assign bus_exc   = bus_op & res_err;

  assign forward_mem_en    = ~kill & (lsu_en_mem ?
                             (bus_op & is_load & res_valid & ~res_err & rd_wr_en_mem) : rd_wr_en_mem);
  assign forward_mem_tag   = rd_wr_tag_mem;
  assign forward_mem_addr  = rd_wr_addr_mem;
  assign forward_mem_wdata = (lsu_en_mem & is_load) ? res_data : rd_wr_data_mem;

  // Bus FSM plus the one-entry buffer for a load that completes while WB is held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      flush_pending <= 1'b0;
      ld_done       <= 1'b0;
      ld_done_err   <= 1'b0;
      ld_done_data  <= 32'h0;
    end else begin
      case (state)
        IDLE:        if (req_idle) state <= data_gnt ? WAIT_RVALID : WAIT_GNT;
        WAIT_GNT:    if (data_gnt) state <= WAIT_RVALID;
        WAIT_RVALID: if (data_rvalid) state <= IDLE;
        default:     state <= IDLE;
      endcase
      if (rsp) flush_pending <= 1'b0;
      else if (flush_M && state != IDLE) flush_pending <= 1'b1;
      if (rsp && !kill && !advance) begin
        ld_done      <= 1'b1;
        ld_done_err  <= data_err;
        ld_done_data <= load_data(lsu_dtype_mem, off, data_rdata);
      end else if (advance || flush_M) begin
        ld_done <= 1'b0;
      end
    end
  end

  // MEM -> WB register boundary
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_wr_en_wb     <= 1'b0;
      rd_wr_tag_wb    <= '0;
      rd_wr_addr_wb   <= 5'h0;
      rd_wr_data_wb   <= 32'h0;
      pc_wb           <= 32'h0;
      exc_taken_wb    <= 1'b0;
      lsu_misalign_ld <= 1'b0;
      lsu_misalign_st <= 1'b0;
      lsu_bus_err     <= 1'b0;
      lsu_exc_addr    <= 32'h0;
    end else begin
      lsu_misalign_ld <= 1'b0;
      lsu_misalign_st <= 1'b0;
      lsu_bus_err     <= 1'b0;
      if (advance) begin
        if (kill || busy) begin
          rd_wr_en_wb  <= 1'b0;
          exc_taken_wb <= 1'b0;
        end else begin
          rd_wr_en_wb     <= rd_wr_en_mem & ~exc_taken_mem & ~(lsu_en_mem & ~is_load) &
                             ~mis_exc & ~bus_exc;
          rd_wr_tag_wb    <= rd_wr_tag_mem;
          rd_wr_addr_wb   <= rd_wr_addr_mem;
          rd_wr_data_wb   <= (bus_op & is_load) ? res_data : rd_wr_data_mem;
          pc_wb           <= pc_mem;
          exc_taken_wb    <= exc_taken_mem | mis_exc | bus_exc;
          lsu_misalign_ld <= mis_exc & is_load;
          lsu_misalign_st <= mis_exc & ~is_load;
          lsu_bus_err     <= bus_exc;
          if (mis_exc || bus_exc) lsu_exc_addr <= lsu_addr_mem;
        end
      end
    end
  end

endmodule
